capture_ctrl: RTL

Sequencing controller for the 512x8 dual-port sample RAM in the acquisition path. It writes a continuous ADC sample stream into the RAM as a circular buffer, holds a programmable number of pre-trigger samples, and stops after the post-trigger portion fills the buffer. It then streams the frozen record out oldest-first through a request/valid read port. It sits between the ADC front end and the host readout logic, driving both RAM ports from a single clock.

---
 rtl/capture_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/capture_ctrl.sv
// capture_ctrl
// ------------
// Sequencing controller for the dual-port sample RAM in the acquisition path.
// It writes the ADC sample stream into the RAM as a circular buffer and keeps
// a programmable number of pre-trigger samples. After a trigger it stops once
// the post-trigger portion has filled the buffer. The frozen record is then
// streamed out oldest-first through a request/valid read port. One clock
// drives both RAM ports.
//
// Parameters
//   ADDR_WIDTH   RAM address width; buffer depth is 2**ADDR_WIDTH
//   DATA_WIDTH   sample width
//
// Ports
//   clk           single clock; also used as RAM wclk and rclk
//   rst           asynchronous, active-low reset
//   start         one-cycle pulse; arms a capture (accepted in IDLE or DONE)
//   pretrigger    pre-trigger sample count, latched on an accepted start
//   sample_valid  sample_data is valid this cycle
//   sample_data   ADC sample
//   trigger_in    trigger qualifier, only looked at together with sample_valid
//   ram_waddr     RAM write address
//   ram_din       RAM write data
//   ram_we        RAM write enable
//   ram_raddr     RAM read address
//   ram_dout      RAM read data (registered inside the RAM)
//   rd_req        host asks for the next sample (honoured in DONE only)
//   rd_data       read sample, straight from ram_dout
//   rd_valid      rd_data is valid
//   busy          capture in progress (PRE, ARMED, POST)
//   done          record frozen and readable (DONE)
//   trig_addr     RAM address of the trigger sample
//                 (only present when CAPTURE_CTRL_TRIG_ADDR_EN is defined)
//
// Optional feature macro: CAPTURE_CTRL_TRIG_ADDR_EN

module capture_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] pretrigger,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  trigger_in,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done
`ifdef CAPTURE_CTRL_TRIG_ADDR_EN
    ,
    output logic [ADDR_WIDTH-1:0] trig_addr
`endif
);

    // Counters are one bit wider than the pointers so they can hold the full
    // buffer depth (a post-trigger run of DEPTH samples when pretrigger is 0).
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH-1:0] pre_q, pre_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH:0]   post_len;
    logic                  rd_valid_q, rd_valid_d;
    logic                  write_en;
`ifdef CAPTURE_CTRL_TRIG_ADDR_EN
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
`endif

    // The write path is purely combinational: every valid sample seen while
    // a capture is running goes into the RAM at the current write pointer.
    assign busy      = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
    assign done      = (state_q == S_DONE);
    assign write_en  = sample_valid & busy;
    assign ram_we    = write_en;
    assign ram_waddr = wptr_q;
    assign ram_din   = sample_data;

    // The RAM registers its read data, so the sample addressed by rptr at
    // a rd_req edge shows up on ram_dout one cycle later, matching rd_valid.
    assign ram_raddr = rptr_q;
    assign rd_data   = ram_dout;
    assign rd_valid  = rd_valid_q;

    // Number of post-trigger samples, trigger sample included.
    assign post_len  = DEPTH_CNT - {1'b0, pre_q};

`ifdef CAPTURE_CTRL_TRIG_ADDR_EN
    assign trig_addr = trig_addr_q;
`endif

    // Next-state and datapath logic. An accepted start takes priority over
    // everything else and restarts from a clean pointer/counter set. When a
    // capture finishes, the read pointer is loaded with the write pointer
    // after the final write: the oldest sample of the circular record.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        pre_d      = pre_q;
        cnt_d      = cnt_q;
        rd_cnt_d   = rd_cnt_q;
        rd_valid_d = 1'b0;
`ifdef CAPTURE_CTRL_TRIG_ADDR_EN
        trig_addr_d = trig_addr_q;
`endif

        if (write_en) begin
            wptr_d = wptr_q + PTR_ONE;
        end

        if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
            wptr_d   = '0;
            cnt_d    = '0;
            rd_cnt_d = '0;
            pre_d    = pretrigger;
            state_d  = (pretrigger == '0) ? S_ARMED : S_PRE;
        end else begin
            case (state_q)
                S_PRE: begin
                    if (write_en) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_d == {1'b0, pre_q}) begin
                            state_d = S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (write_en && trigger_in) begin
                        cnt_d = CNT_ONE;
`ifdef CAPTURE_CTRL_TRIG_ADDR_EN
                        trig_addr_d = wptr_q;
`endif
                        if (post_len == CNT_ONE) begin
                            state_d  = S_DONE;
                            rptr_d   = wptr_d;
                            rd_cnt_d = '0;
                        end else begin
                            state_d = S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (write_en) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_d == post_len) begin
                            state_d  = S_DONE;
                            rptr_d   = wptr_d;
                            rd_cnt_d = '0;
                        end
                    end
                end
                S_DONE: begin
                    if (rd_req) begin
                        rptr_d     = rptr_q + PTR_ONE;
                        rd_cnt_d   = rd_cnt_q + CNT_ONE;
                        rd_valid_d = 1'b1;
                        if (rd_cnt_d == DEPTH_CNT) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and datapath registers; reset aborts any capture or readout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            pre_q      <= '0;
            cnt_q      <= '0;
            rd_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
`ifdef CAPTURE_CTRL_TRIG_ADDR_EN
            trig_addr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_valid_q <= rd_valid_d;
`ifdef CAPTURE_CTRL_TRIG_ADDR_EN
            trig_addr_q <= trig_addr_d;
`endif
        end
    end

endmodule
